// File: rtl/if_fetch.sv
// IF-stage byte sequencer: fetches four bytes at pc..pc+3 through the shared memory port,
// assembles them little-endian and presents the instruction to IF/ID with a valid/ready handshake.
module if_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  mem_busy_i,
  input  logic [7:0]            mem_din_i,
  output logic                  if_request_o,
  output logic [ADDR_WIDTH-1:0] if_mem_addr_o,
  input  logic                  id_ready_i,
  output logic                  inst_valid_o,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [2:0]              issue_cnt_q;
  logic [2:0]              recv_cnt_q;
  logic                    pend_q;
  logic [1:0]              pend_idx_q;
  logic [23:0]             byte_buf_q;
  logic                    inst_valid_q;
  logic [31:0]             inst_q;
  logic [ADDR_WIDTH-1:0]   inst_pc_q;
  logic                    granted;

  assign if_request_o  = rdy & ~rst & ~jump_i & (state_q == FETCH) & (issue_cnt_q < 3'd4);
  assign if_mem_addr_o = if_request_o ? pc_q + {{(ADDR_WIDTH-3){1'b0}}, issue_cnt_q} : '0;
  assign granted       = if_request_o & ~mem_busy_i;

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      pend_q       <= 1'b0;
      pend_idx_q   <= 2'd0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'd0;
      inst_pc_q    <= '0;
    end else if (!rdy) begin
      // Drop any in-flight byte; it is re-requested once rdy returns.
      issue_cnt_q <= recv_cnt_q;
      pend_q      <= 1'b0;
    end else if (jump_i) begin
      state_q      <= FETCH;
      pc_q         <= jump_addr_i;
      issue_cnt_q  <= 3'd0;
      recv_cnt_q   <= 3'd0;
      pend_q       <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (granted) begin
            issue_cnt_q <= issue_cnt_q + 3'd1;
            pend_q      <= 1'b1;
            pend_idx_q  <= issue_cnt_q[1:0];
          end else begin
            pend_q <= 1'b0;
          end
          // Data is only meaningful when IF actually owned the bus last cycle.
          if (pend_q) begin
            recv_cnt_q <= recv_cnt_q + 3'd1;
            case (pend_idx_q)
              2'd0:    byte_buf_q[7:0]   <= mem_din_i;
              2'd1:    byte_buf_q[15:8]  <= mem_din_i;
              2'd2:    byte_buf_q[23:16] <= mem_din_i;
              default: begin
                inst_q       <= {mem_din_i, byte_buf_q};
                inst_pc_q    <= pc_q;
                inst_valid_q <= 1'b1;
                state_q      <= HOLD;
              end
            endcase
          end
        end
        HOLD: begin
          if (id_ready_i) begin
            pc_q         <= pc_q + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
            issue_cnt_q  <= 3'd0;
            recv_cnt_q   <= 3'd0;
            inst_valid_q <= 1'b0;
            state_q      <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule
